// File: rtl/param_core_pkg.sv
// ============================================================================
//  Module      : param_core_pkg
//  Description : Opcodes, FSM state encoding and instruction field offsets
//                shared by the parametrised control core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_INV  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_JFL  = 4'h5;
    localparam logic [3:0] OP_JFE  = 4'h6;
    localparam logic [3:0] OP_JFG  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hA;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Word layout from MSB: op(4) a_reg(1) A(DW) b_reg(1) B(DW) dest(RW)
    function automatic int instr_w(input int dw, input int rw);
        return 4 + 2 * (dw + 1) + rw;
    endfunction

    function automatic int a_flag_pos(input int dw, input int rw);
        return instr_w(dw, rw) - 5;
    endfunction

    function automatic int a_lsb(input int dw, input int rw);
        return instr_w(dw, rw) - 5 - dw;
    endfunction

    function automatic int b_flag_pos(input int dw, input int rw);
        return instr_w(dw, rw) - 6 - dw;
    endfunction

    function automatic int src_lsb(input int dw, input int rw);
        return instr_w(dw, rw) - 4 - rw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
//  Module      : cpu_regfile
//  Description : Register file, two operand reads + one debug read (async),
//                one synchronous write, synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile #(
    parameter int  DATA_W = 8,
    parameter int  NREGS  = 16,
    localparam int RSEL_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [RSEL_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RSEL_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [RSEL_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [RSEL_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                regs_q[gi] <= '0;
            end else if (we_i && (waddr_i == RSEL_W'(gi))) begin
                regs_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/param_control_core.sv
// ============================================================================
//  Module      : param_control_core
//  Description : Multi-cycle fetch/execute control core with ALU, flags,
//                conditional jumps, HALT and a debug register read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_control_core
    import param_core_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NREGS   = 16,
    parameter int  ADDR_W  = 16,
    localparam int RSEL_W  = $clog2(NREGS),
    localparam int INSTR_W = 4 + 2 * (DATA_W + 1) + RSEL_W
) (
    input  logic               clock_i,
    input  logic               reset_i,
    output logic [ADDR_W-1:0]  instr_ptr_o,
    output logic               fetch_req_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               instr_valid_i,
    input  logic [RSEL_W-1:0]  dbg_sel_i,
    output logic [DATA_W-1:0]  dbg_data_o,
    output logic               flag_c_o,
    output logic               flag_z_o,
    output logic               retired_o,
    output logic               halted_o
);

    localparam int C_A_FLAG  = a_flag_pos(DATA_W, RSEL_W);
    localparam int C_A_LSB   = a_lsb(DATA_W, RSEL_W);
    localparam int C_B_FLAG  = b_flag_pos(DATA_W, RSEL_W);
    localparam int C_SRC_LSB = src_lsb(DATA_W, RSEL_W);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q;
    logic [ADDR_W-1:0]    ip_q, ip_d;
    logic                 c_q, c_d, z_q, z_d;

    logic [3:0]           w_op;
    logic [DATA_W-1:0]    w_a_imm, w_b_imm, w_rd_a, w_rd_b, w_opa, w_opb, w_res;
    logic [RSEL_W-1:0]    w_ra, w_dest, w_src;
    logic [ADDR_W-1:0]    w_target;
    logic [DATA_W:0]      w_sum;
    logic                 w_is_jump, w_alu, w_we;

    assign w_op      = ir_q[INSTR_W-1 -: 4];
    assign w_a_imm   = ir_q[C_A_LSB +: DATA_W];
    assign w_b_imm   = ir_q[RSEL_W +: DATA_W];
    assign w_dest    = ir_q[RSEL_W-1:0];
    assign w_src     = ir_q[C_SRC_LSB +: RSEL_W];
    assign w_target  = ir_q[ADDR_W-1:0];
    assign w_is_jump = (w_op == OP_JFL) || (w_op == OP_JFE) || (w_op == OP_JFG);

    // Port A doubles as the jump-condition source read
    assign w_ra  = w_is_jump ? w_src : w_a_imm[RSEL_W-1:0];
    assign w_opa = ir_q[C_A_FLAG] ? w_rd_a : w_a_imm;
    assign w_opb = ir_q[C_B_FLAG] ? w_rd_b : w_b_imm;

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .we_i       (w_we),
        .waddr_i    (w_dest),
        .wdata_i    (w_res),
        .raddr_a_i  (w_ra),
        .rdata_a_o  (w_rd_a),
        .raddr_b_i  (w_b_imm[RSEL_W-1:0]),
        .rdata_b_o  (w_rd_b),
        .dbg_addr_i (dbg_sel_i),
        .dbg_data_o (dbg_data_o)
    );

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        c_d     = c_q;
        z_d     = z_q;
        w_we    = 1'b0;
        w_alu   = 1'b0;
        w_res   = '0;
        w_sum   = {1'b0, w_opa} + {1'b0, w_opb};
        case (state_q)
            ST_FETCH: begin
                if (instr_valid_i) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                ip_d    = ip_q + ADDR_W'(1);
                case (w_op)
                    OP_ADD: begin w_alu = 1'b1; w_res = w_sum[DATA_W-1:0]; c_d = w_sum[DATA_W]; end
                    OP_INV: begin w_alu = 1'b1; w_res = ~w_opa;         c_d = 1'b0; end
                    OP_SUB: begin w_alu = 1'b1; w_res = w_opa - w_opb;  c_d = (w_opa < w_opb); end
                    OP_AND: begin w_alu = 1'b1; w_res = w_opa & w_opb;  c_d = 1'b0; end
                    OP_OR:  begin w_alu = 1'b1; w_res = w_opa | w_opb;  c_d = 1'b0; end
                    OP_XOR: begin w_alu = 1'b1; w_res = w_opa ^ w_opb;  c_d = 1'b0; end
                    OP_JFL: if (w_rd_a[DATA_W-1]) ip_d = w_target;
                    OP_JFE: if (w_rd_a == '0) ip_d = w_target;
                    OP_JFG: if ((w_rd_a != '0) && !w_rd_a[DATA_W-1]) ip_d = w_target;
                    OP_HALT: begin state_d = ST_HALT; ip_d = ip_q; end
                    default: ;
                endcase
                if (w_alu) begin
                    w_we = 1'b1;
                    z_d  = (w_res == '0);
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_FETCH;
            ip_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            c_q     <= c_d;
            z_q     <= z_d;
            if ((state_q == ST_FETCH) && instr_valid_i) ir_q <= instr_i;
        end
    end

    // Status outputs read as idle while reset is held
    assign instr_ptr_o = ip_q;
    assign flag_c_o    = c_q;
    assign flag_z_o    = z_q;
    assign fetch_req_o = (state_q == ST_FETCH) && !reset_i;
    assign retired_o   = (state_q == ST_EXEC)  && !reset_i;
    assign halted_o    = (state_q == ST_HALT)  && !reset_i;

endmodule

`default_nettype wire
